// File: rtl/bird_pos_sequencer_pkg.sv
// Shared definitions for the bird position sequencer: game-state codes,
// idle-flap animation codes and the default off-screen parking coordinate.
package bird_pos_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_MENU     = 3'b000,
    ST_READY    = 3'b001,
    ST_PLAY     = 3'b010,
    ST_GAMEOVER = 3'b011
  } game_state_t;

  typedef enum logic [1:0] {
    ANIM_UP   = 2'd0,
    ANIM_MID  = 2'd1,
    ANIM_DOWN = 2'd2
  } anim_t;

  localparam int unsigned OFF_POS_DEFAULT = 2000;

  function automatic anim_t anim_next(input anim_t a);
    case (a)
      ANIM_UP:  return ANIM_MID;
      ANIM_MID: return ANIM_DOWN;
      default:  return ANIM_UP;
    endcase
  endfunction

endpackage

// File: rtl/bird_pos_sequencer_slide_lane.sv
// One bird's slide-in lane: holds the horizontal slide position and advances
// it by SLIDE_STEP per frame, saturating exactly at TARGET.
module bird_slide_lane #(
  parameter int unsigned POS_W      = 11,
  parameter int unsigned TARGET     = 320,
  parameter int unsigned SLIDE_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             restart,
  output logic [POS_W-1:0] h_next,
  output logic             at_target
);

  localparam logic [POS_W:0]   STEP_X = (POS_W+1)'(SLIDE_STEP);
  localparam logic [POS_W:0]   TGT_X  = (POS_W+1)'(TARGET);
  localparam logic [POS_W-1:0] TGT    = POS_W'(TARGET);

  logic [POS_W-1:0] h;
  logic [POS_W:0]   sum;

  // One extra bit on the sum so a step past the target never wraps.
  always_comb begin
    sum = {1'b0, h} + STEP_X;
    if (restart)
      h_next = '0;
    else if (sum >= TGT_X)
      h_next = TGT;
    else
      h_next = sum[POS_W-1:0];
    at_target = (h_next == TGT);
  end

  always_ff @(posedge clk) begin
    if (rst)
      h <= '0;
    else if (tick)
      h <= h_next;
  end

endmodule

// File: rtl/bird_pos_sequencer.sv
// Per-frame bird position/animation sequencer; all outputs change only on
// frame_tick. Optional GAMEOVER death blink: define BIRD_DEATH_BLINK_EN.
module bird_pos_sequencer
  import bird_pos_sequencer_pkg::*;
#(
  parameter int unsigned NUM_BIRDS     = 2,
  parameter int unsigned POS_W         = 11,
  parameter int unsigned OFF_POS       = OFF_POS_DEFAULT,
  parameter int unsigned MENU_H        = 320,
  parameter int unsigned MENU_V        = 285,
  parameter int unsigned START_H       = 320,
  parameter int unsigned START_V       = 240,
  parameter int unsigned START_SPACING = 40,
  parameter int unsigned SLIDE_STEP    = 8,
  parameter int unsigned ANIM_DIV      = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic [2:0]                 game_state,
  input  logic [NUM_BIRDS-1:0]       active_mask,
  input  logic [NUM_BIRDS*POS_W-1:0] bird_h_in,
  input  logic [NUM_BIRDS*POS_W-1:0] bird_v_in,
  input  logic [NUM_BIRDS*2-1:0]     bird_anim_in,
  input  logic [NUM_BIRDS-1:0]       dead_mask,
  output logic [NUM_BIRDS*POS_W-1:0] bird_h_out,
  output logic [NUM_BIRDS*POS_W-1:0] bird_v_out,
  output logic [NUM_BIRDS*2-1:0]     bird_anim_out,
  output logic                       slide_done
);

  localparam logic [POS_W-1:0] OFF_W    = POS_W'(OFF_POS);
  localparam logic [POS_W-1:0] MENU_HW  = POS_W'(MENU_H);
  localparam logic [POS_W-1:0] MENU_VW  = POS_W'(MENU_V);
  localparam logic [POS_W-1:0] START_VW = POS_W'(START_V);
  localparam int unsigned      CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  if (NUM_BIRDS < 1 || NUM_BIRDS > 4 ||
      START_H < (NUM_BIRDS - 1) * START_SPACING ||
      64'(OFF_POS) >= (64'(1) << POS_W)) begin : g_param_check
    $error("bird_pos_sequencer: illegal parameter combination");
  end

  game_state_t          st, prev_state;
  logic [NUM_BIRDS-1:0] prev_active;
  logic [CNT_W-1:0]     cnt, cnt_cur;
  anim_t                anim_idle;
  logic                 run, wrap, entry_ready;

  logic [POS_W-1:0]     lane_h [NUM_BIRDS];
  logic [NUM_BIRDS-1:0] lane_at, restart;

  logic [NUM_BIRDS*POS_W-1:0] h_nx, v_nx;
  logic [NUM_BIRDS*2-1:0]     a_nx;
  logic                       slide_done_nx;

`ifdef BIRD_DEATH_BLINK_EN
  logic blink_phase, phase_cur, go_entry;
`else
  logic unused_dead;
  assign unused_dead = ^dead_mask;
`endif

  always_comb begin
    case (game_state)
      ST_MENU:     st = ST_MENU;
      ST_READY:    st = ST_READY;
      ST_GAMEOVER: st = ST_GAMEOVER;
      default:     st = ST_PLAY;
    endcase
  end

  assign entry_ready = (st == ST_READY) && (prev_state != ST_READY);

  // Blink phase and frame counter restart on GAMEOVER entry so the blink
  // always opens with a full visible period.
  always_comb begin
    cnt_cur = cnt;
    run     = (st == ST_MENU) || (st == ST_READY);
`ifdef BIRD_DEATH_BLINK_EN
    go_entry  = (st == ST_GAMEOVER) && (prev_state != ST_GAMEOVER);
    phase_cur = go_entry ? 1'b0 : blink_phase;
    if (st == ST_GAMEOVER) run = 1'b1;
    if (go_entry) cnt_cur = '0;
`endif
    wrap = (cnt_cur == CNT_LAST);
  end

  for (genvar g = 0; g < NUM_BIRDS; g++) begin : g_lane
    assign restart[g] = (st != ST_READY) || entry_ready ||
                        !active_mask[g] || !prev_active[g];
    bird_slide_lane #(
      .POS_W      (POS_W),
      .TARGET     (START_H - g * START_SPACING),
      .SLIDE_STEP (SLIDE_STEP)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .tick      (frame_tick),
      .restart   (restart[g]),
      .h_next    (lane_h[g]),
      .at_target (lane_at[g])
    );
  end

  always_comb begin
    h_nx = '0;
    v_nx = '0;
    a_nx = '0;
    for (int unsigned i = 0; i < NUM_BIRDS; i++) begin
      h_nx[i*POS_W +: POS_W] = OFF_W;
      v_nx[i*POS_W +: POS_W] = OFF_W;
      a_nx[i*2 +: 2]         = '0;
      if (active_mask[i]) begin
        case (st)
          ST_MENU: begin
            if (i == 0) begin
              h_nx[i*POS_W +: POS_W] = MENU_HW;
              v_nx[i*POS_W +: POS_W] = MENU_VW;
              a_nx[i*2 +: 2]         = anim_idle;
            end
          end
          ST_READY: begin
            h_nx[i*POS_W +: POS_W] = lane_h[i];
            v_nx[i*POS_W +: POS_W] = START_VW;
            a_nx[i*2 +: 2]         = anim_idle;
          end
          default: begin
            h_nx[i*POS_W +: POS_W] = bird_h_in[i*POS_W +: POS_W];
            v_nx[i*POS_W +: POS_W] = bird_v_in[i*POS_W +: POS_W];
            a_nx[i*2 +: 2]         = bird_anim_in[i*2 +: 2];
`ifdef BIRD_DEATH_BLINK_EN
            if (st == ST_GAMEOVER && dead_mask[i] && phase_cur) begin
              h_nx[i*POS_W +: POS_W] = OFF_W;
              v_nx[i*POS_W +: POS_W] = OFF_W;
              a_nx[i*2 +: 2]         = '0;
            end
`endif
          end
        endcase
      end
    end
    slide_done_nx = (st == ST_READY) && !entry_ready &&
                    (&(lane_at | ~active_mask));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bird_h_out    <= {NUM_BIRDS{OFF_W}};
      bird_v_out    <= {NUM_BIRDS{OFF_W}};
      bird_anim_out <= '0;
      slide_done    <= 1'b0;
      prev_state    <= ST_MENU;
      prev_active   <= '0;
      cnt           <= '0;
      anim_idle     <= ANIM_UP;
`ifdef BIRD_DEATH_BLINK_EN
      blink_phase   <= 1'b0;
`endif
    end else if (frame_tick) begin
      bird_h_out    <= h_nx;
      bird_v_out    <= v_nx;
      bird_anim_out <= a_nx;
      slide_done    <= slide_done_nx;
      prev_state    <= st;
      prev_active   <= active_mask;
      if (run) begin
        cnt <= wrap ? '0 : cnt_cur + CNT_W'(1);
        if (wrap) anim_idle <= anim_next(anim_idle);
      end else begin
        cnt       <= '0;
        anim_idle <= ANIM_UP;
      end
`ifdef BIRD_DEATH_BLINK_EN
      if (st == ST_GAMEOVER)
        blink_phase <= wrap ? ~phase_cur : phase_cur;
      else
        blink_phase <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_bird_pos_sequencer.sv
// Scoreboard bench for bird_pos_sequencer: a reference model pushes expected
// outputs per frame_tick; a monitor pops and compares one clk later.
module tb_bird_pos_sequencer;

  localparam int NB  = 2;
  localparam int PW  = 11;
  localparam int OFF = 2000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_tick = 1'b0;
  logic [2:0]      game_state = 3'b000;
  logic [NB-1:0]   active_mask = '0;
  logic [NB*PW-1:0] bird_h_in = '0, bird_v_in = '0;
  logic [NB*2-1:0] bird_anim_in = '0;
  logic [NB-1:0]   dead_mask = '0;
  logic [NB*PW-1:0] bird_h_out, bird_v_out;
  logic [NB*2-1:0] bird_anim_out;
  logic            slide_done;

  always #5 clk = ~clk;

  bird_pos_sequencer #(
    .NUM_BIRDS(2), .POS_W(11), .OFF_POS(2000), .MENU_H(320), .MENU_V(285),
    .START_H(320), .START_V(240), .START_SPACING(40), .SLIDE_STEP(8), .ANIM_DIV(6)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_state(game_state),
    .active_mask(active_mask), .bird_h_in(bird_h_in), .bird_v_in(bird_v_in),
    .bird_anim_in(bird_anim_in), .dead_mask(dead_mask), .bird_h_out(bird_h_out),
    .bird_v_out(bird_v_out), .bird_anim_out(bird_anim_out), .slide_done(slide_done)
  );

  typedef struct {
    logic [NB*PW-1:0] h;
    logic [NB*PW-1:0] v;
    logic [NB*2-1:0]  a;
    logic             sd;
    int               n;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int total = 0, bad = 0, tick_n = 0;
  int m_prev, m_cnt, m_idle, m_blink;
  int mh[NB];
  logic [NB-1:0] m_pa;
  logic tick_seen = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.h = {NB{11'(OFF)}};
    e.v = {NB{11'(OFF)}};
    e.a = '0;
    e.sd = 1'b0;
    e.n = -1;
    return e;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_cnt = 0; m_idle = 0; m_blink = 0; m_pa = '0;
    for (int i = 0; i < NB; i++) mh[i] = 0;
    last = reset_exp();
  endtask

  task automatic model_step(input logic [2:0] gs, input logic [NB-1:0] am,
                            input logic [NB*PW-1:0] hi, input logic [NB*PW-1:0] vi,
                            input logic [NB*2-1:0] ai, input logic [NB-1:0] dm,
                            output exp_t e);
    int st, tgt, h, v, a;
    bit entry, all_at, run, wrap;
    st = (gs <= 3'd3) ? int'(gs) : 2;
    entry = (st == 1) && (m_prev != 1);
`ifdef BIRD_DEATH_BLINK_EN
    if (st == 3 && m_prev != 3) begin m_cnt = 0; m_blink = 0; end
`endif
    all_at = 1;
    e.n = tick_n;
    for (int i = 0; i < NB; i++) begin
      tgt = 320 - 40 * i;
      if (st == 1) begin
        if (entry || !am[i] || !m_pa[i]) mh[i] = 0;
        else if (mh[i] + 8 > tgt) mh[i] = tgt;
        else mh[i] = mh[i] + 8;
      end
      h = OFF; v = OFF; a = 0;
      if (am[i]) begin
        if (st == 0) begin
          if (i == 0) begin h = 320; v = 285; a = m_idle; end
        end else if (st == 1) begin
          h = mh[i]; v = 240; a = m_idle;
          if (mh[i] != tgt) all_at = 0;
        end else begin
          h = int'(hi[i*PW +: PW]); v = int'(vi[i*PW +: PW]); a = int'(ai[i*2 +: 2]);
`ifdef BIRD_DEATH_BLINK_EN
          if (st == 3 && dm[i] && m_blink != 0) begin h = OFF; v = OFF; a = 0; end
`endif
        end
      end
      e.h[i*PW +: PW] = 11'(h);
      e.v[i*PW +: PW] = 11'(v);
      e.a[i*2 +: 2]   = 2'(a);
    end
    e.sd = (st == 1) && !entry && all_at;
    run = (st == 0) || (st == 1);
`ifdef BIRD_DEATH_BLINK_EN
    if (st == 3) run = 1;
`endif
    wrap = 0;
    if (run) begin
      if (m_cnt == 5) begin m_cnt = 0; m_idle = (m_idle + 1) % 3; wrap = 1; end
      else m_cnt++;
    end else begin
      m_cnt = 0; m_idle = 0;
    end
`ifdef BIRD_DEATH_BLINK_EN
    if (st == 3) begin if (wrap) m_blink = m_blink ^ 1; end
    else m_blink = 0;
`else
    if (dm != dm) m_blink = 1;
`endif
    m_prev = st;
    m_pa = am;
  endtask

  always @(posedge clk) tick_seen <= frame_tick && !rst;

  always @(negedge clk) begin
    if (tick_seen) begin
      if (q.size() == 0) begin
        check_val("sb_underflow", 64'(q.size()), 64'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_val($sformatf("t%0d h", e.n), 64'(bird_h_out), 64'(e.h));
        check_val($sformatf("t%0d v", e.n), 64'(bird_v_out), 64'(e.v));
        check_val($sformatf("t%0d anim", e.n), 64'(bird_anim_out), 64'(e.a));
        check_val($sformatf("t%0d slide_done", e.n), 64'(slide_done), 64'(e.sd));
        last = e;
      end
    end
  end

  task automatic do_tick(input logic [2:0] gs, input logic [NB-1:0] am,
                         input logic [NB*PW-1:0] hi, input logic [NB*PW-1:0] vi,
                         input logic [NB*2-1:0] ai, input logic [NB-1:0] dm);
    exp_t e;
    int gap;
    @(negedge clk);
    game_state = gs; active_mask = am; bird_h_in = hi; bird_v_in = vi;
    bird_anim_in = ai; dead_mask = dm; frame_tick = 1'b1;
    tick_n++;
    model_step(gs, am, hi, vi, ai, dm, e);
    q.push_back(e);
    @(negedge clk);
    frame_tick = 1'b0;
    gap = int'($urandom_range(0, 2));
    for (int k = 0; k < gap; k++) begin
      bird_h_in = NB*PW'($urandom); bird_v_in = NB*PW'($urandom);
      bird_anim_in = NB*2'($urandom); game_state = 3'($urandom);
      @(negedge clk);
      check_val($sformatf("t%0d hold", tick_n),
                64'({bird_h_out, bird_v_out, bird_anim_out, slide_done}),
                64'({last.h, last.v, last.a, last.sd}));
    end
  endtask

  task automatic tick_rand(input logic [2:0] gs, input logic [NB-1:0] am, input logic [NB-1:0] dm);
    do_tick(gs, am, NB*PW'($urandom), NB*PW'($urandom), NB*2'($urandom), dm);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " h"}, 64'(bird_h_out), 64'({NB{11'(OFF)}}));
    check_val({tag, " v"}, 64'(bird_v_out), 64'({NB{11'(OFF)}}));
    check_val({tag, " anim"}, 64'(bird_anim_out), 64'd0);
    check_val({tag, " slide_done"}, 64'(slide_done), 64'd0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // MENU: bird0 at menu spot with idle flap, bird1 parked
    for (int k = 1; k <= 20; k++) tick_rand(3'b000, 2'b11, 2'b00);

    // READY slide-in
    for (int k = 1; k <= 45; k++) begin
      tick_rand(3'b001, 2'b11, 2'b00);
      if (k == 36) check_val("b1_stop_280", 64'(bird_h_out[PW +: PW]), 64'd280);
      if (k == 40) check_val("slide_done_pre", 64'(slide_done), 64'd0);
      if (k == 41) check_val("slide_done_rise", 64'(slide_done), 64'd1);
      if (k == 41) check_val("b0_at_320", 64'(bird_h_out[0 +: PW]), 64'd320);
    end

    // PLAY pass-through
    for (int k = 1; k <= 4; k++)
      do_tick(3'b010, 2'b11, {11'd100, 11'd100}, {11'd77, 11'd77}, {2'd2, 2'd2}, 2'b00);
    check_val("play_b0_h", 64'(bird_h_out[0 +: PW]), 64'd100);
    for (int k = 1; k <= 3; k++)
      do_tick(3'b010, 2'b01, {11'd50, 11'd100}, {11'd50, 11'd77}, {2'd1, 2'd2}, 2'b00);
    check_val("inactive_b1_h", 64'(bird_h_out[PW +: PW]), 64'd2000);
    check_val("inactive_b1_anim", 64'(bird_anim_out[3:2]), 64'd0);

    // Reset mid-slide at bird0 h=160, then restart the line-up
    tick_rand(3'b000, 2'b11, 2'b00);
    for (int k = 1; k <= 21; k++) tick_rand(3'b001, 2'b11, 2'b00);
    check_val("b0_mid_160", 64'(bird_h_out[0 +: PW]), 64'd160);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    model_reset();
    tick_rand(3'b001, 2'b11, 2'b00);
    check_val("reentry_b0_h0", 64'(bird_h_out[0 +: PW]), 64'd0);
    for (int k = 1; k <= 3; k++) tick_rand(3'b001, 2'b11, 2'b00);
    for (int k = 1; k <= 5; k++) tick_rand(3'b001, 2'b01, 2'b00);
    for (int k = 1; k <= 40; k++) tick_rand(3'b001, 2'b11, 2'b00);

    // Undefined state code behaves as PLAY; GAMEOVER with a dead bird
    for (int k = 1; k <= 2; k++) tick_rand(3'b110, 2'b11, 2'b00);
    for (int k = 1; k <= 14; k++) tick_rand(3'b011, 2'b11, 2'b10);
    for (int k = 1; k <= 2; k++) tick_rand(3'b000, 2'b11, 2'b00);

    repeat (3) @(negedge clk);
    check_val("sb_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
